mult_div: RTL and testbench

Multicycle signed multiply/divide responder for the MIPS datapath. Accepts one-cycle `mult_start`/`div_start` requests from the control unit with operands from registers A and B. Iterates 32 cycles and delivers the 64-bit result into the HI/LO pair. Reports divide-by-zero back to the control unit so it can raise the exception.

---
 rtl/mult_div_pkg.sv | 35 +++
 rtl/abs_neg.sv | 24 ++
 rtl/mult_div.sv | 179 +++++++++++++++++
 tb/tb_mult_div.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_pkg
// Description : Shared types and constants for the multicycle signed
//               multiply/divide unit and the control unit that drives it.
//               - state_t      : iteration FSM states (IDLE, MULT, DIV)
//               - ITER_LAST    : last iteration index at the default width
//               - RES_SEL_*    : HI/LO result-select codes for the datapath
//               - iter_last()  : last iteration index for any width
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // One partial product / quotient bit per cycle, so the last count
    // index is one below the operand width.
    localparam int ITER_LAST = WIDTH_DEFAULT - 1;

    // Result-select codes used by the control unit for mfhi/mflo.
    localparam logic RES_SEL_LO = 1'b0;
    localparam logic RES_SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic int iter_last(input int w);
        return w - 1;
    endfunction

endpackage : mult_div_pkg
`default_nettype wire

// File: rtl/abs_neg.sv
`default_nettype none
// ============================================================================
// Module      : abs_neg
// Description : Conditional two's-complement negate.
//               Ports:
//                 in_val  [W-1:0]  value to pass or negate
//                 neg              1 = output -in_val, 0 = output in_val
//                 out_val [W-1:0]  result
//               Used for operand magnitudes (neg = sign bit) and for the
//               final sign correction of product, quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? ({W{1'b0}} - in_val) : in_val;

endmodule : abs_neg
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
// Module      : mult_div
// Description : Multicycle signed multiply/divide unit for the MIPS HI/LO
//               pair. Shift-add multiply and restoring divide on operand
//               magnitudes, WIDTH iterations, sign-corrected on the last one.
//               Ports:
//                 clk, reset            clock, synchronous active-high reset
//                 mult_start, div_start one-cycle requests, sampled in IDLE
//                 a_in, b_in            multiplicand/dividend, mult./divisor
//                 hi_out, lo_out        product[2W-1:W]/[W-1:0] or rem/quot
//                 busy                  high while iterating
//                 done                  one-cycle pulse, results updated
//                 div_zero              one-cycle pulse, divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                 C_CNT_W    = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(iter_last(WIDTH));
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    // Mult: {partial product high, multiplier shifting out / product low}.
    // Div : {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mag;      // |multiplicand| or |divisor|
    logic                 r_neg_lo;   // sign of product / quotient
    logic                 r_neg_hi;   // sign of remainder (dividend sign)

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_shift;
    logic [WIDTH:0]       w_rem_diff;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    abs_neg #(.W(WIDTH)) u_abs_a (
        .in_val (a_in),
        .neg    (a_in[WIDTH-1]),
        .out_val(w_a_mag)
    );

    abs_neg #(.W(WIDTH)) u_abs_b (
        .in_val (b_in),
        .neg    (b_in[WIDTH-1]),
        .out_val(w_b_mag)
    );

    // Shift-add step: add the multiplicand into the high half when the
    // current multiplier bit (acc LSB) is set, then shift right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mag} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder, try to
    // subtract the divisor, keep the difference only if it is non-negative.
    // The remainder is always below the divisor, so WIDTH+1 bits suffice.
    assign w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_mag};
    assign w_q_bit     = ~w_rem_diff[WIDTH];
    assign w_div_next  = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_q_bit};

    // Sign correction is applied to the step result so the final iteration
    // and the output register update happen on the same edge.
    abs_neg #(.W(2*WIDTH)) u_fix_prod (
        .in_val (w_mul_next),
        .neg    (r_neg_lo),
        .out_val(w_prod_fix)
    );

    abs_neg #(.W(WIDTH)) u_fix_quo (
        .in_val (w_div_next[WIDTH-1:0]),
        .neg    (r_neg_lo),
        .out_val(w_quo_fix)
    );

    abs_neg #(.W(WIDTH)) u_fix_rem (
        .in_val (w_div_next[2*WIDTH-1:WIDTH]),
        .neg    (r_neg_hi),
        .out_val(w_rem_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mag    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (mult_start) begin
                        r_mag    <= w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                        r_neg_lo <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        r_neg_hi <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= MULT;
                    end else if (div_start) begin
                        if (b_in != '0) begin
                            r_mag    <= w_b_mag;
                            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                            r_neg_lo <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            r_neg_hi <= a_in[WIDTH-1];
                            busy     <= 1'b1;
                            r_state  <= DIV;
                        end else begin
                            div_zero <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + C_CNT_ONE;
                    if (r_cnt == C_CNT_LAST) begin
                        hi_out  <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_out  <= w_prod_fix[WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + C_CNT_ONE;
                    if (r_cnt == C_CNT_LAST) begin
                        hi_out  <= w_rem_fix;
                        lo_out  <= w_quo_fix;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mult_div
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div
// Description : Directed self-checking bench for mult_div. Cycle numbering:
//               the request is sampled at the edge ending cycle 0, and
//               outputs are sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mult_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mult_start(mult_start),
        .div_start (div_start),
        .a_in      (a_in),
        .b_in      (b_in),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request; returns in cycle 1.
    task automatic issue(input logic do_mult, input logic do_div,
                         input logic [31:0] a, input logic [31:0] b);
        mult_start = do_mult;
        div_start  = do_div;
        a_in       = a;
        b_in       = b;
        step();
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    // From cycle 1, wait (bounded) for done; cyc is the cycle where done
    // was seen (40 on timeout), busy_cyc the number of busy cycles before it.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        mult_start = 1'b1;
        div_start  = 1'b0;
        a_in       = 32'd3;
        b_in       = 32'd5;
        repeat (3) step();
        mult_start = 1'b0;
        total_cnt++; if (hi_out !== 32'h0) $display("FAIL reset_hi got %h want %h", hi_out, 32'h0); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'h0) $display("FAIL reset_lo got %h want %h", lo_out, 32'h0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero got %b want 0", div_zero); else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_prio_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_mult_signed();
        int cyc, bc;
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        total_cnt++; if (busy !== 1'b1) $display("FAIL mult_busy_c1 got %b want 1", busy); else pass_cnt++;
        wait_done(cyc, bc);
        total_cnt++; if (cyc !== 33) $display("FAIL mult_done_cycle got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (bc !== 32) $display("FAIL mult_busy_cycles got %0d want 32", bc); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_c33 got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi got %h want %h", hi_out, 32'hFFFF_FFFF); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo got %h want %h", lo_out, 32'hFFFF_FFEB); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b want 0", done); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'hFFFF_FFEB) $display("FAIL mult_hold_lo got %h want %h", lo_out, 32'hFFFF_FFEB); else pass_cnt++;
    endtask

    task automatic test_both_starts();
        int cyc, bc;
        // 6 * -7 = -42; the divide (quotient 0) must lose.
        issue(1'b1, 1'b1, 32'd6, 32'hFFFF_FFF9);
        wait_done(cyc, bc);
        total_cnt++; if (cyc !== 33) $display("FAIL both_done_cycle got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'hFFFF_FFFF) $display("FAIL both_hi got %h want %h", hi_out, 32'hFFFF_FFFF); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'hFFFF_FFD6) $display("FAIL both_lo got %h want %h", lo_out, 32'hFFFF_FFD6); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, bc);
        total_cnt++; if (hi_out !== 32'h4000_0000) $display("FAIL mult_min_hi got %h want %h", hi_out, 32'h4000_0000); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'h0000_0000) $display("FAIL mult_min_lo got %h want %h", lo_out, 32'h0); else pass_cnt++;
        // New request sampled in the done cycle.
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else pass_cnt++;
        wait_done(cyc, bc);
        total_cnt++; if (cyc !== 33) $display("FAIL b2b_done_cycle got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h want %h", lo_out, 32'hFFFF_FFFD); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h want %h", hi_out, 32'hFFFF_FFFF); else pass_cnt++;
    endtask

    task automatic test_div_overflow();
        int cyc, bc;
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bc);
        total_cnt++; if (cyc !== 33) $display("FAIL ovf_done_cycle got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (bc !== 32) $display("FAIL ovf_busy_cycles got %0d want 32", bc); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'h8000_0000) $display("FAIL ovf_lo got %h want %h", lo_out, 32'h8000_0000); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'h0000_0000) $display("FAIL ovf_hi got %h want %h", hi_out, 32'h0); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        int dz_cnt, busy_cnt, done_cnt;
        // Preload HI/LO with -1 / -3.
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bc);
        step();
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_pulse got %b want 1", div_zero); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL dz_busy_c1 got %b want 0", busy); else pass_cnt++;
        dz_cnt = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 2; k <= 40; k++) begin
            step();
            if (div_zero === 1'b1) dz_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        total_cnt++; if (dz_cnt !== 0) $display("FAIL dz_extra_pulses got %0d want 0", dz_cnt); else pass_cnt++;
        total_cnt++; if (busy_cnt !== 0) $display("FAIL dz_busy_cycles got %0d want 0", busy_cnt); else pass_cnt++;
        total_cnt++; if (done_cnt !== 0) $display("FAIL dz_done_cycles got %0d want 0", done_cnt); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'hFFFF_FFFF) $display("FAIL dz_hold_hi got %h want %h", hi_out, 32'hFFFF_FFFF); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'hFFFF_FFFD) $display("FAIL dz_hold_lo got %h want %h", lo_out, 32'hFFFF_FFFD); else pass_cnt++;
    endtask

    task automatic test_ignore_and_reset();
        int cyc, bc;
        int done_cnt, busy_cnt;
        issue(1'b1, 1'b0, 32'd3, 32'd4);            // now cycle 1
        repeat (4) step();                          // cycle 5
        div_start = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
        step();                                     // cycle 6
        div_start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ignore_busy got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL ignore_dz got %b want 0", div_zero); else pass_cnt++;
        repeat (4) step();                          // cycle 10
        reset = 1'b1;
        step();                                     // cycle 11
        reset = 1'b0;
        total_cnt++; if (hi_out !== 32'h0) $display("FAIL midrst_hi got %h want %h", hi_out, 32'h0); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'h0) $display("FAIL midrst_lo got %h want %h", lo_out, 32'h0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL midrst_dz got %b want 0", div_zero); else pass_cnt++;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        total_cnt++; if (done_cnt !== 0) $display("FAIL midrst_no_done got %0d want 0", done_cnt); else pass_cnt++;
        total_cnt++; if (busy_cnt !== 0) $display("FAIL midrst_no_busy got %0d want 0", busy_cnt); else pass_cnt++;
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        wait_done(cyc, bc);
        total_cnt++; if (cyc !== 33) $display("FAIL fresh_done_cycle got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (lo_out !== 32'd12) $display("FAIL fresh_lo got %h want %h", lo_out, 32'd12); else pass_cnt++;
        total_cnt++; if (hi_out !== 32'd0) $display("FAIL fresh_hi got %h want %h", hi_out, 32'd0); else pass_cnt++;
    endtask

    initial begin
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a_in       = 32'h0;
        b_in       = 32'h0;
        test_reset();
        test_mult_signed();
        test_both_starts();
        test_back_to_back();
        test_div_overflow();
        test_div_zero();
        test_ignore_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mult_div
`default_nettype wire
